uart_cmd_bridge: RTL and testbench

//   Byte-level command responder between a UART byte receiver/transmitter pair and an on-chip memory bus.

---
 rtl/uart_cmd_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// ---------------------------------------------------------------------------
// uart_cmd_bridge
//   Byte-level command responder that lets a PC reach on-chip registers and
//   memory through a UART receiver/transmitter pair.
//
//   Host commands, with all multi-byte fields sent MSB first:
//     'W' (0x57) + ADDR_BYTES address + DATA_BYTES data -> one bus write, reply 0x4B
//     'R' (0x52) + ADDR_BYTES address                   -> one bus read, reply the data
//     anything else                                     -> reply 0x3F
//
//   A command whose bytes stop arriving for TIMEOUT cycles is dropped. In that
//   case there is no bus cycle and no reply.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_data_i    received byte, valid while rx_ready_i is high
//   rx_ready_i   received byte pending; stays high until it is cleared
//   rx_clear_o   one-cycle pulse: the pending byte has been consumed
//   tx_start_o   one-cycle pulse: transmit tx_data_o
//   tx_data_o    byte to transmit; held from tx_start_o until the next tx_start_o
//   tx_busy_i    transmitter busy
//   bus_addr_o   transaction address
//   bus_wdata_o  write data
//   bus_we_o     write request, held until bus_ack_i
//   bus_re_o     read request, held until bus_ack_i
//   bus_rdata_i  read data, sampled in the bus_ack_i cycle
//   bus_ack_i    transaction complete
// ---------------------------------------------------------------------------
module uart_cmd_bridge #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 250000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_ready_i,
  output logic                    rx_clear_o,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_busy_i,
  output logic [8*ADDR_BYTES-1:0] bus_addr_o,
  output logic [8*DATA_BYTES-1:0] bus_wdata_o,
  output logic                    bus_we_o,
  output logic                    bus_re_o,
  input  logic [8*DATA_BYTES-1:0] bus_rdata_i,
  input  logic                    bus_ack_i
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] DATA_CNT  = CW'(DATA_BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_TXW
  } state_e;

  state_e          state_q;
  logic            isWrite_q;
  logic [CW-1:0]   byteCnt_q;
  logic [TW-1:0]   tmoCnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rspBuf_q;
  logic [CW-1:0]   rspLeft_q;
  logic            txwHold_q;
  logic            rxClear_q;
  logic            txStart_q;
  logic [7:0]      txData_q;
  logic            busWe_q;
  logic            busRe_q;
  logic            rxAccept;

  // A byte is taken only in the parsing states. While rx_clear_o is high,
  // rx_ready_i may still show the byte that is being cleared, so that cycle
  // does not count as a new byte.
  assign rxAccept = rx_ready_i && !rxClear_q &&
                    ((state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      isWrite_q <= 1'b0;
      byteCnt_q <= '0;
      tmoCnt_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rspBuf_q  <= '0;
      rspLeft_q <= '0;
      txwHold_q <= 1'b0;
      rxClear_q <= 1'b0;
      txStart_q <= 1'b0;
      txData_q  <= '0;
      busWe_q   <= 1'b0;
      busRe_q   <= 1'b0;
    end else begin
      rxClear_q <= rxAccept;
      txStart_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rxAccept) begin
            byteCnt_q <= '0;
            tmoCnt_q  <= '0;
            if (rx_data_i == CMD_WRITE) begin
              isWrite_q <= 1'b1;
              state_q   <= S_ADDR;
            end else if (rx_data_i == CMD_READ) begin
              isWrite_q <= 1'b0;
              state_q   <= S_ADDR;
            end else begin
              rspBuf_q  <= DW'(RSP_ERR) << (DW - 8);
              rspLeft_q <= CW'(1);
              state_q   <= S_RESP;
            end
          end
        end

        // The address always gets a full ADDR_BYTES shifts. Leftover bits
        // from an aborted command are therefore pushed out.
        S_ADDR: begin
          if (rxAccept) begin
            addr_q   <= (addr_q << 8) | AW'(rx_data_i);
            tmoCnt_q <= '0;
            if (byteCnt_q == ADDR_LAST) begin
              byteCnt_q <= '0;
              if (isWrite_q) begin
                state_q <= S_DATA;
              end else begin
                busRe_q <= 1'b1;
                state_q <= S_BUS;
              end
            end else begin
              byteCnt_q <= byteCnt_q + CW'(1);
            end
          end else if (tmoCnt_q == TMO_LAST) begin
            tmoCnt_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            tmoCnt_q <= tmoCnt_q + TW'(1);
          end
        end

        S_DATA: begin
          if (rxAccept) begin
            wdata_q  <= (wdata_q << 8) | DW'(rx_data_i);
            tmoCnt_q <= '0;
            if (byteCnt_q == DATA_LAST) begin
              byteCnt_q <= '0;
              busWe_q   <= 1'b1;
              state_q   <= S_BUS;
            end else begin
              byteCnt_q <= byteCnt_q + CW'(1);
            end
          end else if (tmoCnt_q == TMO_LAST) begin
            tmoCnt_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            tmoCnt_q <= tmoCnt_q + TW'(1);
          end
        end

        // The request was raised on the edge that entered this state, so an
        // ack in the first BUS cycle completes the transfer.
        S_BUS: begin
          if (bus_ack_i) begin
            busWe_q <= 1'b0;
            busRe_q <= 1'b0;
            state_q <= S_RESP;
            if (isWrite_q) begin
              rspBuf_q  <= DW'(RSP_OK) << (DW - 8);
              rspLeft_q <= CW'(1);
            end else begin
              rspBuf_q  <= bus_rdata_i;
              rspLeft_q <= DATA_CNT;
            end
          end
        end

        S_RESP: begin
          if (!tx_busy_i) begin
            txData_q  <= rspBuf_q[DW-1 -: 8];
            txStart_q <= 1'b1;
            rspBuf_q  <= rspBuf_q << 8;
            rspLeft_q <= rspLeft_q - CW'(1);
            txwHold_q <= 1'b1;
            state_q   <= S_TXW;
          end
        end

        // tx_busy_i rises one cycle after tx_start_o. The first TXW cycle is
        // skipped so that the stale low value is not taken as "done".
        S_TXW: begin
          if (txwHold_q) begin
            txwHold_q <= 1'b0;
          end else if (!tx_busy_i) begin
            state_q <= (rspLeft_q == '0) ? S_IDLE : S_RESP;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_clear_o  = rxClear_q;
  assign tx_start_o  = txStart_q;
  assign tx_data_o   = txData_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_we_o    = busWe_q;
  assign bus_re_o    = busRe_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_bridge
//   Directed, table-driven bench for uart_cmd_bridge. The bench models:
//     - a host RX that holds rx_ready high until it sees rx_clear at an edge,
//     - a bus slave that acks a set number of cycles after the request,
//     - a transmitter whose busy flag rises one cycle after tx_start.
//   The command table is followed by separate sequences for the timeout case
//   and for a reset during a response.
// ---------------------------------------------------------------------------
module tb_uart_cmd_bridge;

  localparam int TMO     = 20;
  localparam int BUSYLEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady = 1'b0;
  logic        rxClear;
  logic        txStart;
  logic [7:0]  txData;
  logic        txBusy = 1'b0;
  logic [15:0] busAddr;
  logic [31:0] busWdata;
  logic        busWe;
  logic        busRe;
  logic [31:0] busRdata = 32'h0;
  logic        busAck = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_cmd_bridge #(
    .ADDR_BYTES (2),
    .DATA_BYTES (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rxData),
    .rx_ready_i  (rxReady),
    .rx_clear_o  (rxClear),
    .tx_start_o  (txStart),
    .tx_data_o   (txData),
    .tx_busy_i   (txBusy),
    .bus_addr_o  (busAddr),
    .bus_wdata_o (busWdata),
    .bus_we_o    (busWe),
    .bus_re_o    (busRe),
    .bus_rdata_i (busRdata),
    .bus_ack_i   (busAck)
  );

  always #5 clk = ~clk;

  // Count rx_clear pulses.
  int rxClearCount = 0;
  always @(negedge clk) begin
    if (rxClear) rxClearCount++;
  end

  // Transmitter model: log each started byte. Busy rises one cycle after the
  // start and stays high for BUSYLEN cycles. A start is a violation if busy
  // was high at the edge that produced it or at the edge before that one.
  int          txCount = 0;
  int          txViol  = 0;
  logic [7:0]  txLog [0:63];
  logic        startPend = 1'b0;
  logic        busyPrev  = 1'b0;
  int          busyLeft  = 0;
  always @(negedge clk) begin
    if (txStart && (txBusy || busyPrev)) txViol++;
    if (txStart) begin
      if (txCount < 64) txLog[txCount] = txData;
      txCount++;
    end
    busyPrev = txBusy;
    if (startPend) begin
      startPend = 1'b0;
      txBusy    = 1'b1;
      busyLeft  = BUSYLEN;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) txBusy = 1'b0;
    end
    if (txStart) startPend = 1'b1;
  end

  // Bus slave: ack curAckDelay cycles after the first cycle of the request.
  // The request must be gone in the cycle after the ack.
  int          curAckDelay = 0;
  logic [31:0] curRdata = 32'h0;
  int          busCyc = 0;
  int          weCycles = 0;
  int          reCycles = 0;
  int          ackCount = 0;
  int          dropFails = 0;
  logic [15:0] seenAddr = 16'h0;
  logic [31:0] seenWdata = 32'h0;
  always @(negedge clk) begin
    if (busAck) begin
      busAck = 1'b0;
      busCyc = 0;
      if (busWe || busRe) dropFails++;
    end else if (busWe || busRe) begin
      if (busWe) weCycles++;
      if (busRe) reCycles++;
      if (busCyc == curAckDelay) begin
        busAck    = 1'b1;
        busRdata  = curRdata;
        seenAddr  = busAddr;
        seenWdata = busWdata;
        ackCount++;
      end
      busCyc++;
    end else begin
      busCyc = 0;
    end
  end

  typedef struct {
    int          nBytes;
    logic [55:0] rxBytes;
    int          gap;
    int          ackDelay;
    logic [31:0] rdata;
    logic        expWe;
    logic        expRe;
    logic [15:0] expAddr;
    logic [31:0] expWdata;
    int          expTxN;
    logic [31:0] expTx;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one byte. Hold rx_ready through the edge that already shows
  // rx_clear, as a real sticky receiver does, and then drop it.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    rxData  = b;
    rxReady = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rxClear && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rxByteTaken", 64'(rxClear), 64'd1);
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  task automatic runVec(input string name, input vec_t v);
    int          txBase, rxcBase, weBase, reBase, ackBase, violBase, dropBase, n;
    logic [7:0]  b;
    logic [7:0]  e;
    txBase   = txCount;
    rxcBase  = rxClearCount;
    weBase   = weCycles;
    reBase   = reCycles;
    ackBase  = ackCount;
    violBase = txViol;
    dropBase = dropFails;
    curAckDelay = v.ackDelay;
    curRdata    = v.rdata;
    for (int i = 0; i < v.nBytes; i++) begin
      b = v.rxBytes[55-8*i -: 8];
      applyStimulus(b);
      repeat (v.gap) @(negedge clk);
    end
    if (v.expWe || v.expRe) begin
      n = 0;
      while (ackCount == ackBase && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput({name, ".ackCount"}, 64'(ackCount - ackBase), 64'd1);
      checkOutput({name, ".addr"}, 64'(seenAddr), 64'(v.expAddr));
      if (v.expWe) checkOutput({name, ".wdata"}, 64'(seenWdata), 64'(v.expWdata));
    end
    n = 0;
    while ((txCount - txBase) < v.expTxN && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    checkOutput({name, ".txCount"}, 64'(txCount - txBase), 64'(v.expTxN));
    for (int i = 0; i < v.expTxN; i++) begin
      e = v.expTx[31-8*i -: 8];
      checkOutput({name, ".txByte"}, 64'(txLog[(txBase + i) % 64]), 64'(e));
    end
    checkOutput({name, ".weCycles"}, 64'(weCycles - weBase), v.expWe ? 64'(v.ackDelay + 1) : 64'd0);
    checkOutput({name, ".reCycles"}, 64'(reCycles - reBase), v.expRe ? 64'(v.ackDelay + 1) : 64'd0);
    checkOutput({name, ".rxClears"}, 64'(rxClearCount - rxcBase), 64'(v.nBytes));
    checkOutput({name, ".txSpacing"}, 64'(txViol - violBase), 64'd0);
    checkOutput({name, ".reqDrop"}, 64'(dropFails - dropBase), 64'd0);
  endtask

  initial begin
    int   txBase, rxcBase, weBase, reBase, n;
    vec_t tv;

    //        nB  bytes                        gap ack rdata         we    re    addr      wdata         txN txBytes
    vecs[0] = '{7, 56'h57_1234_DEADBEEF,       0,  3,  32'h0,        1'b1, 1'b0, 16'h1234, 32'hDEADBEEF, 1, 32'h4B000000};
    vecs[1] = '{3, 56'h52_0010_00000000,       0,  2,  32'hCAFEF00D, 1'b0, 1'b1, 16'h0010, 32'h0,        4, 32'hCAFEF00D};
    vecs[2] = '{1, 56'h41_0000_00000000,       0,  0,  32'h0,        1'b0, 1'b0, 16'h0,    32'h0,        1, 32'h3F000000};
    vecs[3] = '{3, 56'h52_0010_00000000,       0,  0,  32'h12345678, 1'b0, 1'b1, 16'h0010, 32'h0,        4, 32'h12345678};
    vecs[4] = '{7, 56'h57_ABCD_01020304,       12, 1,  32'h0,        1'b1, 1'b0, 16'hABCD, 32'h01020304, 1, 32'h4B000000};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", 64'({rxClear, txStart, txData, busAddr, busWdata, busWe, busRe}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Abandoned write: no bus cycle and no reply. The next read must use
    // only its own address bytes.
    txBase  = txCount;
    rxcBase = rxClearCount;
    weBase  = weCycles;
    reBase  = reCycles;
    applyStimulus(8'h57);
    applyStimulus(8'h12);
    repeat (TMO + 10) @(negedge clk);
    checkOutput("tmo.weCycles", 64'(weCycles - weBase), 64'd0);
    checkOutput("tmo.reCycles", 64'(reCycles - reBase), 64'd0);
    checkOutput("tmo.txCount", 64'(txCount - txBase), 64'd0);
    checkOutput("tmo.rxClears", 64'(rxClearCount - rxcBase), 64'd2);
    tv = '{3, 56'h52_0010_00000000, 0, 1, 32'hA5A50F0F, 1'b0, 1'b1, 16'h0010, 32'h0, 4, 32'hA5A50F0F};
    runVec("tmoRead", tv);

    // Reset during the response, after two of the four read bytes.
    txBase = txCount;
    curAckDelay = 1;
    curRdata    = 32'hCAFEF00D;
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    n = 0;
    while ((txCount - txBase) < 2 && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("rst.txBeforeReset", 64'(txCount - txBase), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.outputsZero", 64'({rxClear, txStart, txData, busAddr, busWdata, busWe, busRe}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("rst.noMoreTx", 64'(txCount - txBase), 64'd2);
    checkOutput("rst.txByte0", 64'(txLog[txBase % 64]), 64'h00CA);
    checkOutput("rst.txByte1", 64'(txLog[(txBase + 1) % 64]), 64'h00FE);
    runVec("afterReset", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
